// File: rtl/alu_result_merger.sv
// Dual-ALU result merger: two buffered result channels, merged round-robin
// into one tagged valid/ready output stream, with saturating drop counters.

module alu_result_chan #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [DW+1:0]    entry_i,
   input  logic             pop_i,
   output logic [DW+1:0]    head_o,
   output logic             nempty_o,
   output logic             full_o,
   output logic [CNT_W-1:0] drop_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      CNT_ONE  = 1;
   localparam logic [AW:0]      CNT_FULL = DEPTH[AW:0];
   localparam logic [AW-1:0]    PTR_ONE  = 1;
   localparam logic [CNT_W-1:0] DROP_ONE = 1;
   localparam logic [CNT_W-1:0] DROP_MAX = '1;

   logic [DW+1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             full_q;
   logic [CNT_W-1:0] drop_q;
   logic             push_ok, do_pop;

   // Fullness is judged on the start-of-cycle count, so a pop never frees a slot for a same-cycle push.
   assign push_ok = push_i & ~full_q;
   assign do_pop  = pop_i & (cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q;
      case ({push_ok, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= entry_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         drop_q   <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         cnt_q  <= cnt_d;
         full_q <= (cnt_d == CNT_FULL);
         if (push_i && full_q && drop_q != DROP_MAX) drop_q <= drop_q + DROP_ONE;
      end
   end

   assign head_o   = mem_q[rd_ptr_q];
   assign nempty_o = (cnt_q != '0);
   assign full_o   = full_q;
   assign drop_o   = drop_q;
endmodule

module alu_result_merger #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             res1_valid_i,
   input  logic [DW-1:0]    res1_data_i,
   input  logic             res1_zero_i,
   input  logic             res1_ovf_i,
   input  logic             res2_valid_i,
   input  logic [DW-1:0]    res2_data_i,
   input  logic             res2_zero_i,
   input  logic             res2_ovf_i,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [DW+2:0]    out_data_o,
   output logic             full1_o,
   output logic             full2_o,
   output logic [CNT_W-1:0] drop1_o,
   output logic [CNT_W-1:0] drop2_o
);
   typedef enum logic {ST_EMPTY, ST_LOADED} state_t;

   state_t        state_q;
   logic [DW+2:0] out_data_q;
   logic          last_src_q;

   logic [DW+1:0] head1, head2, head_sel;
   logic          nempty1, nempty2, any_ne, sel, load_en, pop1, pop2;

   alu_result_chan #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan1 (
      .clk      (clk),
      .rst      (rst),
      .push_i   (res1_valid_i),
      .entry_i  ({res1_data_i, res1_zero_i, res1_ovf_i}),
      .pop_i    (pop1),
      .head_o   (head1),
      .nempty_o (nempty1),
      .full_o   (full1_o),
      .drop_o   (drop1_o)
   );

   alu_result_chan #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan2 (
      .clk      (clk),
      .rst      (rst),
      .push_i   (res2_valid_i),
      .entry_i  ({res2_data_i, res2_zero_i, res2_ovf_i}),
      .pop_i    (pop2),
      .head_o   (head2),
      .nempty_o (nempty2),
      .full_o   (full2_o),
      .drop_o   (drop2_o)
   );

   // sel=1 grants channel 2; with both pending the channel not served last wins.
   assign any_ne   = nempty1 | nempty2;
   assign sel      = (nempty1 & nempty2) ? ~last_src_q : nempty2;
   assign load_en  = (state_q == ST_EMPTY) | out_ready_i;
   assign pop1     = load_en & any_ne & ~sel;
   assign pop2     = load_en & any_ne & sel;
   assign head_sel = sel ? head2 : head1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         out_data_q <= '0;
         last_src_q <= 1'b1;
      end else if (load_en) begin
         if (any_ne) begin
            state_q    <= ST_LOADED;
            out_data_q <= {sel, head_sel[1], head_sel[0], head_sel[DW+1:2]};
            last_src_q <= sel;
         end else begin
            state_q <= ST_EMPTY;
         end
      end
   end

   assign out_valid_o = (state_q == ST_LOADED);
   assign out_data_o  = out_data_q;
endmodule

// File: tb/tb_alu_result_merger.sv
// Bench for alu_result_merger: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_alu_result_merger;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             res1_valid = 1'b0, res1_zero = 1'b0, res1_ovf = 1'b0;
   logic [DW-1:0]    res1_data = '0;
   logic             res2_valid = 1'b0, res2_zero = 1'b0, res2_ovf = 1'b0;
   logic [DW-1:0]    res2_data = '0;
   logic             out_ready = 1'b0;
   logic             out_valid;
   logic [DW+2:0]    out_data;
   logic             full1, full2;
   logic [CNT_W-1:0] drop1, drop2;

   int checks = 0;
   int errors = 0;

   alu_result_merger #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .res1_valid_i (res1_valid),
      .res1_data_i  (res1_data),
      .res1_zero_i  (res1_zero),
      .res1_ovf_i   (res1_ovf),
      .res2_valid_i (res2_valid),
      .res2_data_i  (res2_data),
      .res2_zero_i  (res2_zero),
      .res2_ovf_i   (res2_ovf),
      .out_ready_i  (out_ready),
      .out_valid_o  (out_valid),
      .out_data_o   (out_data),
      .full1_o      (full1),
      .full2_o      (full2),
      .drop1_o      (drop1),
      .drop2_o      (drop2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one queue per channel plus an output holding slot.
   typedef struct {
      logic [7:0] d;
      logic       z;
      logic       o;
   } ent_t;

   ent_t        q1[$];
   ent_t        q2[$];
   bit          m_valid;
   logic [10:0] m_data;
   bit          m_last;
   int          m_drop1, m_drop2;

   always @(posedge clk or posedge rst) begin
      bit   f1, f2, src, have;
      ent_t e;
      if (rst) begin
         q1.delete();
         q2.delete();
         m_valid = 0;
         m_data  = '0;
         m_last  = 1;
         m_drop1 = 0;
         m_drop2 = 0;
      end else begin
         f1 = (q1.size() == DEPTH);
         f2 = (q2.size() == DEPTH);
         if (!m_valid || out_ready) begin
            have = 1;
            if (q1.size() > 0 && q2.size() > 0) src = !m_last;
            else if (q1.size() > 0)             src = 0;
            else if (q2.size() > 0)             src = 1;
            else                                have = 0;
            if (have) begin
               e = src ? q2.pop_front() : q1.pop_front();
               m_data  = {src, e.z, e.o, e.d};
               m_valid = 1;
               m_last  = src;
            end else begin
               m_valid = 0;
            end
         end
         if (res1_valid) begin
            if (!f1) q1.push_back('{res1_data, res1_zero, res1_ovf});
            else if (m_drop1 < 255) m_drop1++;
         end
         if (res2_valid) begin
            if (!f2) q2.push_back('{res2_data, res2_zero, res2_ovf});
            else if (m_drop2 < 255) m_drop2++;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_out_valid", 32'(out_valid), 32'(m_valid));
         chk("model_out_data",  32'(out_data),  32'(m_data));
         chk("model_full1",     32'(full1),     32'(q1.size() == DEPTH));
         chk("model_full2",     32'(full2),     32'(q2.size() == DEPTH));
         chk("model_drop1",     32'(drop1),     32'(m_drop1));
         chk("model_drop2",     32'(drop2),     32'(m_drop2));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #5 rst = 1'b0;
   endtask

   task automatic idle_inputs();
      res1_valid = 1'b0;
      res2_valid = 1'b0;
      res1_zero  = 1'b0;
      res1_ovf   = 1'b0;
      res2_zero  = 1'b0;
      res2_ovf   = 1'b0;
   endtask

   initial begin
      logic [10:0] seen[$];

      #1 rst = 1'b1;
      #6 rst = 1'b0;

      // Reset state
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      chk("rst_full1",     32'(full1),     32'h0);
      chk("rst_full2",     32'(full2),     32'h0);
      chk("rst_drop1",     32'(drop1),     32'h0);
      chk("rst_drop2",     32'(drop2),     32'h0);

      // Single result: latency two edges, one-cycle output
      out_ready  = 1'b1;
      res1_valid = 1'b1; res1_data = 8'h5A; res1_zero = 1'b0; res1_ovf = 1'b1;
      tick();
      idle_inputs();
      chk("t1_valid_k1", 32'(out_valid), 32'h0);
      tick();
      chk("t1_valid_k2", 32'(out_valid), 32'h1);
      chk("t1_data",     32'(out_data),  32'h15A);
      tick();
      chk("t1_valid_k3", 32'(out_valid), 32'h0);
      chk("t1_drop1",    32'(drop1),     32'h0);

      // Dual stream alternation
      do_reset();
      out_ready = 1'b1;
      res1_data = 8'h11; res2_data = 8'h22;
      for (int i = 0; i < 20; i++) begin
         res1_valid = (i < 4);
         res2_valid = (i < 4);
         tick();
         if (out_valid) seen.push_back(out_data);
      end
      idle_inputs();
      chk("t2_count", 32'(seen.size()), 32'd8);
      for (int i = 0; i < seen.size() && i < 8; i++)
         chk("t2_seq", 32'(seen[i]), (i % 2 == 0) ? 32'h011 : 32'h422);

      // Backpressure, fill, drop and drain
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         res1_valid = 1'b1; res1_data = 8'(i);
         tick();
         if (i >= 2) chk("t3_hold", 32'(out_data), 32'h001);
         if (i == 4) chk("t3_full_after4", 32'(full1), 32'h0);
         if (i == 5) chk("t3_full_after5", 32'(full1), 32'h1);
      end
      idle_inputs();
      chk("t3_drop1", 32'(drop1), 32'h1);
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         chk("t3_drain_valid", 32'(out_valid), 32'h1);
         chk("t3_drain_data",  32'(out_data),  32'(i));
         tick();
      end
      chk("t3_empty", 32'(out_valid), 32'h0);

      // Push while full and popping
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         res1_valid = 1'b1; res1_data = 8'(i);
         tick();
      end
      chk("t4_full_before", 32'(full1), 32'h1);
      out_ready = 1'b1; res1_valid = 1'b1; res1_data = 8'h09;
      tick();
      idle_inputs();
      chk("t4_drop1", 32'(drop1), 32'h1);
      chk("t4_full_after", 32'(full1), 32'h0);
      for (int i = 2; i <= 5; i++) begin
         chk("t4_drain", 32'(out_data), 32'(i));
         tick();
      end
      chk("t4_empty", 32'(out_valid), 32'h0);

      // Drop counter saturation
      do_reset();
      out_ready = 1'b0;
      res2_valid = 1'b1;
      for (int i = 0; i < 5 + 260; i++) begin
         res2_data = 8'(i);
         tick();
      end
      chk("t5_drop2_sat", 32'(drop2), 32'd255);
      tick();
      idle_inputs();
      chk("t5_drop2_hold", 32'(drop2), 32'd255);

      // Asynchronous reset mid-transfer
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         res1_valid = 1'b1; res1_data = 8'(8'h30 + i);
         res2_valid = 1'b1; res2_data = 8'(8'h40 + i);
         tick();
      end
      idle_inputs();
      chk("t6_pre_valid", 32'(out_valid), 32'h1);
      chk("t6_pre_drop1", 32'(drop1), 32'h1);
      chk("t6_pre_drop2", 32'(drop2), 32'h2);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_valid", 32'(out_valid), 32'h0);
      chk("t6_async_full1", 32'(full1), 32'h0);
      chk("t6_async_full2", 32'(full2), 32'h0);
      chk("t6_async_drop1", 32'(drop1), 32'h0);
      chk("t6_async_drop2", 32'(drop2), 32'h0);
      #3 rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t6_no_stale", 32'(out_valid), 32'h0);
      end

      // Randomized traffic against the model
      do_reset();
      for (int seg = 0; seg < 6; seg++) begin
         int p1, p2, pr;
         p1 = $urandom_range(10, 90);
         p2 = $urandom_range(10, 90);
         pr = $urandom_range(5, 100);
         for (int i = 0; i < 500; i++) begin
            res1_valid = ($urandom_range(0, 99) < p1);
            res2_valid = ($urandom_range(0, 99) < p2);
            res1_data  = 8'($urandom);
            res2_data  = 8'($urandom);
            res1_zero  = 1'($urandom);
            res1_ovf   = 1'($urandom);
            res2_zero  = 1'($urandom);
            res2_ovf   = 1'($urandom);
            out_ready  = ($urandom_range(0, 99) < pr);
            tick();
         end
      end
      idle_inputs();
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("rand_final_empty", 32'(out_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
